amber_ptw: RTL and testbench
============================

Name: amber_ptw

Overview:
Hardware page-table walker for amber_mmu. It sits downstream of the TLB miss path and upstream of the TLB fill path. On a DTLB/ITLB miss it walks a 4-level radix table (9-bit indices, 4 KiB pages, 48-bit VA) over a single memory read port. It then emits either one TLB fill (VPN, PPN, perm, G, ASID tag) or one fault.

Parameters:
LEVELS, 4, number of table levels; VA index bits = 9*LEVELS = 36 = VPN width
PTE_W, 48, PTE width returned by memory

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
iw_req_valid  in  1  walk request
ow_req_ready  out  1  high only in IDLE
iw_req_vpn  in  36  missing VPN (VA[47:12])
iw_req_asid  in  16  current ASID; low 8 bits become fill tag
iw_root_ppn  in  30  root table PPN (from MMU CSR), sampled at request accept
iw_abort  in  1  abandon current walk (flush)
iw_inv  in  1  TLBINV_ALL/ASID/page; clears walk cache
ow_mem_req_valid  out  1  PTE read request
iw_mem_req_ready  in  1  memory accepts request
ow_mem_req_addr  out  48  PTE byte address
iw_mem_resp_valid  in  1  PTE returned
iw_mem_resp_data  in  48  PTE
iw_mem_resp_err  in  1  bus error on read
ow_fill_valid  out  1  1-cycle fill pulse
ow_fill_vpn  out  36  fill VPN
ow_fill_ppn  out  30  fill PPN
ow_fill_perm  out  6  {2'b00,U,X,W,R}
ow_fill_global  out  1  G bit
ow_fill_asid  out  8  iw_req_asid[7:0]
ow_fault_valid  out  1  1-cycle fault pulse
ow_fault_code  out  3  0 NOT_PRESENT, 2 BUS_ERR, 3 BAD_LEAF
ow_fault_vpn  out  36  faulting VPN
ow_busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0): state IDLE. All outputs 0 except ow_req_ready=1. Level counter 3. Walk cache invalid.
- PTE format: [0] V, [1] R, [2] W, [3] X, [4] U, [5] G, [41:12] PPN, others ignored.
- A PTE is a leaf if any of R/W/X is set; otherwise it is a pointer to the next table at PPN.
- Level L index: VPN[9L+8:9L].
- Address: {6'd0, table_ppn, idx, 3'b000}.
- States:
  - IDLE: on req_valid&&req_ready, latch vpn/asid/root, level=3 → REQ.
  - REQ: mem_req_valid=1, addr stable until mem_req_ready; on handshake → WAIT.
  - WAIT: on mem_resp_valid, evaluate in priority order:
    - err → fault code 2
    - !V → code 0
    - leaf at level>0 → code 3
    - leaf at level 0 → fill
    - pointer at level 0 → code 0
    - otherwise table_ppn=PPN, level-1 → REQ
  - DONE: exactly one of fill_valid/fault_valid=1 for one cycle, payload valid only that cycle → IDLE. ow_req_ready=1 again the following cycle.
  - DRAIN: entered on abort while in WAIT. Waits for the outstanding mem_resp_valid, discards it, → IDLE. No fill or fault is emitted.
- Abort in REQ before the handshake → IDLE next cycle. Abort in IDLE/DONE is ignored (DONE pulse still emitted). Abort has priority over resp_valid in the same cycle.
- Latency, zero-wait memory (ready=1, response 1 cycle after accept): accept edge N; mem_req_valid at N+1; each level takes 2 cycles; fill pulse at N+9.
- Exactly one memory request is outstanding at a time. mem_resp_valid outside WAIT/DRAIN is ignored.
- rst assertion mid-walk returns to the reset state immediately. The memory side must be reset together with this block.

Optional Feature:
PTW_CACHE_EN:
- With the macro defined: a single-entry walk cache holds {VPN[35:9], root_ppn, level-0 table PPN}. It is written when a level-1 pointer PTE is consumed.
- On request accept, if the entry is valid and both VPN[35:9] and root match, the walk starts at level 0 with the cached PPN. Latency becomes N+3 at zero-wait.
- The entry is cleared on iw_inv, on any fault, and on reset. iw_inv takes effect in the same cycle and also suppresses a same-cycle write.
- Without the macro: no cache storage; iw_inv is ignored; every walk performs 4 reads.

Test Plan:
- Basic walk. Setup: root 0x100, VPN 0x1. Memory: 0x100000→PTE ppn 0x101 V; 0x101000→0x102 V; 0x102000→0x103 V; 0x103008→leaf ppn 0x2, V|R|W, asid 0x0001. Expect addresses in that order; fill_vpn=0x1, ppn=0x2, perm=6'b000011, global=0, asid=0x01; pulse at N+9.
- Not present: level-1 PTE with V=0 → fault_valid, code 0, vpn 0x1. No fill. Exactly 3 reads.
- Bad leaf and bus error:
  - level-2 PTE V|R → code 3.
  - mem_resp_err on the first read → code 2.
- Backpressure: hold mem_req_ready=0 for 5 cycles at level 2 → addr 0x101000 held stable, single handshake, walk completes correctly.
- Abort in WAIT at level 1 with the response arriving 3 cycles later → no fill or fault, busy drops the cycle after the response, next request is accepted normally.
- PTW_CACHE_EN: repeat the basic walk with VPN 0x2 → single read at 0x103010. Then pulse iw_inv and repeat → 4 reads.

Source files
------------

// File: rtl/amber_ptw.sv
// 4-level radix page-table walker: one PTE read at a time, ends in one TLB fill or one fault.
// Zero-wait fill at accept+9 (+3 on a walk-cache hit with PTW_CACHE_EN); mem_req stalls hold the address.
module amber_ptw #(
   parameter int LEVELS = 4,
   parameter int PTE_W  = 48
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iw_req_valid,
   output logic                  ow_req_ready,
   input  logic [9*LEVELS-1:0]   iw_req_vpn,
   input  logic [15:0]           iw_req_asid,
   input  logic [29:0]           iw_root_ppn,
   input  logic                  iw_abort,
   input  logic                  iw_inv,
   output logic                  ow_mem_req_valid,
   input  logic                  iw_mem_req_ready,
   output logic [47:0]           ow_mem_req_addr,
   input  logic                  iw_mem_resp_valid,
   input  logic [PTE_W-1:0]      iw_mem_resp_data,
   input  logic                  iw_mem_resp_err,
   output logic                  ow_fill_valid,
   output logic [9*LEVELS-1:0]   ow_fill_vpn,
   output logic [29:0]           ow_fill_ppn,
   output logic [5:0]            ow_fill_perm,
   output logic                  ow_fill_global,
   output logic [7:0]            ow_fill_asid,
   output logic                  ow_fault_valid,
   output logic [2:0]            ow_fault_code,
   output logic [9*LEVELS-1:0]   ow_fault_vpn,
   output logic                  ow_busy
);
   localparam int VPN_W = 9 * LEVELS;
   localparam int LVL_W = $clog2(LEVELS);
   localparam logic [2:0] FC_NOT_PRESENT = 3'd0;
   localparam logic [2:0] FC_BUS_ERR     = 3'd2;
   localparam logic [2:0] FC_BAD_LEAF    = 3'd3;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

   state_t             state, state_nxt;
   logic [VPN_W-1:0]   vpn_q;
   logic [7:0]         asid_q;
   logic [29:0]        table_ppn;
   logic [LVL_W-1:0]   level;
   logic               is_fault;
   logic [2:0]         fault_code_q, fault_code_nxt;
   logic [29:0]        fill_ppn_q;
   logic [5:0]         perm_q;
   logic               glb_q;
   logic [8:0]         idx;
   logic               accept, walk_step, fill_set, fault_set;
   logic               cache_hit;
   logic [29:0]        cache_ppn_w;
   logic               unused_bits;

   logic        pte_v, pte_leaf;
   logic [29:0] pte_ppn;
   assign pte_v    = iw_mem_resp_data[0];
   assign pte_leaf = |iw_mem_resp_data[3:1];
   assign pte_ppn  = iw_mem_resp_data[41:12];

   always_comb begin
      idx = '0;
      for (int l = 0; l < LEVELS; l++)
         if (LVL_W'(l) == level) idx = vpn_q[9*l +: 9];
   end

   always_comb begin
      state_nxt      = state;
      accept         = 1'b0;
      walk_step      = 1'b0;
      fill_set       = 1'b0;
      fault_set      = 1'b0;
      fault_code_nxt = FC_NOT_PRESENT;
      case (state)
         S_IDLE: if (iw_req_valid) begin
            accept    = 1'b1;
            state_nxt = S_REQ;
         end
         S_REQ: begin
            // an abort that coincides with the handshake still owes us a response
            if (iw_abort)              state_nxt = iw_mem_req_ready ? S_DRAIN : S_IDLE;
            else if (iw_mem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (iw_abort) begin
               state_nxt = iw_mem_resp_valid ? S_IDLE : S_DRAIN;
            end else if (iw_mem_resp_valid) begin
               state_nxt = S_DONE;
               if (iw_mem_resp_err) begin
                  fault_set      = 1'b1;
                  fault_code_nxt = FC_BUS_ERR;
               end else if (!pte_v) begin
                  fault_set = 1'b1;
               end else if (pte_leaf && level != '0) begin
                  fault_set      = 1'b1;
                  fault_code_nxt = FC_BAD_LEAF;
               end else if (pte_leaf) begin
                  fill_set = 1'b1;
               end else if (level == '0) begin
                  fault_set = 1'b1;
               end else begin
                  walk_step = 1'b1;
                  state_nxt = S_REQ;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         S_DRAIN: if (iw_mem_resp_valid) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vpn_q        <= '0;
         asid_q       <= '0;
         table_ppn    <= '0;
         level        <= LVL_W'(LEVELS - 1);
         is_fault     <= 1'b0;
         fault_code_q <= '0;
         fill_ppn_q   <= '0;
         perm_q       <= '0;
         glb_q        <= 1'b0;
      end else begin
         if (accept) begin
            vpn_q     <= iw_req_vpn;
            asid_q    <= iw_req_asid[7:0];
            table_ppn <= cache_hit ? cache_ppn_w : iw_root_ppn;
            level     <= cache_hit ? '0 : LVL_W'(LEVELS - 1);
         end
         if (walk_step) begin
            table_ppn <= pte_ppn;
            level     <= level - LVL_W'(1);
         end
         if (fill_set) begin
            is_fault   <= 1'b0;
            fill_ppn_q <= pte_ppn;
            perm_q     <= {2'b00, iw_mem_resp_data[4:1]};
            glb_q      <= iw_mem_resp_data[5];
         end
         if (fault_set) begin
            is_fault     <= 1'b1;
            fault_code_q <= fault_code_nxt;
         end
      end
   end

`ifdef PTW_CACHE_EN
   logic               cache_vld;
   logic [VPN_W-10:0]  cache_tag;
   logic [29:0]        cache_root, cache_ppn, root_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_vld  <= 1'b0;
         cache_tag  <= '0;
         cache_root <= '0;
         cache_ppn  <= '0;
         root_q     <= '0;
      end else begin
         if (accept) root_q <= iw_root_ppn;
         // the level-1 pointer names the leaf table shared by all VPNs with this prefix
         if (iw_inv || fault_set) begin
            cache_vld <= 1'b0;
         end else if (walk_step && level == LVL_W'(1)) begin
            cache_vld  <= 1'b1;
            cache_tag  <= vpn_q[VPN_W-1:9];
            cache_root <= root_q;
            cache_ppn  <= pte_ppn;
         end
      end
   end

   assign cache_hit   = cache_vld && !iw_inv && cache_tag == iw_req_vpn[VPN_W-1:9]
                        && cache_root == iw_root_ppn;
   assign cache_ppn_w = cache_ppn;
   assign unused_bits = ^{iw_req_asid[15:8], iw_mem_resp_data[PTE_W-1:42], iw_mem_resp_data[11:6]};
`else
   assign cache_hit   = 1'b0;
   assign cache_ppn_w = '0;
   assign unused_bits = ^{iw_inv, iw_req_asid[15:8], iw_mem_resp_data[PTE_W-1:42],
                          iw_mem_resp_data[11:6]};
`endif

   assign ow_req_ready     = (state == S_IDLE);
   assign ow_busy          = (state != S_IDLE);
   assign ow_mem_req_valid = (state == S_REQ);
   assign ow_mem_req_addr  = ow_mem_req_valid ? {6'd0, table_ppn, idx, 3'b000} : '0;

   assign ow_fill_valid  = (state == S_DONE) && !is_fault;
   assign ow_fill_vpn    = ow_fill_valid ? vpn_q : '0;
   assign ow_fill_ppn    = ow_fill_valid ? fill_ppn_q : '0;
   assign ow_fill_perm   = ow_fill_valid ? perm_q : '0;
   assign ow_fill_global = ow_fill_valid && glb_q;
   assign ow_fill_asid   = ow_fill_valid ? asid_q : '0;

   assign ow_fault_valid = (state == S_DONE) && is_fault;
   assign ow_fault_code  = ow_fault_valid ? fault_code_q : '0;
   assign ow_fault_vpn   = ow_fault_valid ? vpn_q : '0;
endmodule

// File: tb/tb_amber_ptw.sv
// Directed bench for amber_ptw with a reactive PTE memory (stall, delay and error injection).
module tb_amber_ptw;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [35:0] req_vpn = '0;
   logic [15:0] req_asid = '0;
   logic [29:0] root_ppn = '0;
   logic        abort = 1'b0, inv = 1'b0;
   logic        mem_req_valid, mem_req_ready;
   logic [47:0] mem_req_addr;
   logic        mem_resp_valid, mem_resp_err;
   logic [47:0] mem_resp_data;
   logic        fill_valid, fill_global, fault_valid, busy;
   logic [35:0] fill_vpn, fault_vpn;
   logic [29:0] fill_ppn;
   logic [5:0]  fill_perm;
   logic [7:0]  fill_asid;
   logic [2:0]  fault_code;

   amber_ptw dut (
      .clk(clk), .rst(rst),
      .iw_req_valid(req_valid), .ow_req_ready(req_ready), .iw_req_vpn(req_vpn),
      .iw_req_asid(req_asid), .iw_root_ppn(root_ppn), .iw_abort(abort), .iw_inv(inv),
      .ow_mem_req_valid(mem_req_valid), .iw_mem_req_ready(mem_req_ready),
      .ow_mem_req_addr(mem_req_addr), .iw_mem_resp_valid(mem_resp_valid),
      .iw_mem_resp_data(mem_resp_data), .iw_mem_resp_err(mem_resp_err),
      .ow_fill_valid(fill_valid), .ow_fill_vpn(fill_vpn), .ow_fill_ppn(fill_ppn),
      .ow_fill_perm(fill_perm), .ow_fill_global(fill_global), .ow_fill_asid(fill_asid),
      .ow_fault_valid(fault_valid), .ow_fault_code(fault_code), .ow_fault_vpn(fault_vpn),
      .ow_busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // memory model: zero-wait unless the address matches a stall or delay setting
   logic [47:0] mem [logic [47:0]];
   logic [47:0] rd_log [$];
   logic [47:0] stall_addr = '1, delay_addr = '1, err_addr = '1;
   int          stall_req = 0, stall_base = 0, stall_seen = 0, delay_cycles = 0;
   int          pend = 0;
   logic [47:0] pend_a;
   int          fill_cnt = 0, fault_cnt = 0;

   function automatic logic [47:0] pte(input logic [29:0] ppn, input logic [5:0] fl);
      return {6'd0, ppn, 6'd0, fl};
   endfunction

   function automatic logic [47:0] rd(input logic [47:0] a);
      return mem.exists(a) ? mem[a] : 48'd0;
   endfunction

   assign mem_req_ready = !(mem_req_valid && mem_req_addr == stall_addr
                            && (stall_seen - stall_base) < stall_req);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_resp_valid <= 1'b0;
         mem_resp_data  <= '0;
         mem_resp_err   <= 1'b0;
         pend           <= 0;
      end else begin
         mem_resp_valid <= 1'b0;
         mem_resp_data  <= '0;
         mem_resp_err   <= 1'b0;
         if (pend > 1) pend <= pend - 1;
         else if (pend == 1) begin
            mem_resp_valid <= 1'b1;
            mem_resp_data  <= rd(pend_a);
            mem_resp_err   <= (pend_a == err_addr);
            pend           <= 0;
         end
         if (mem_req_valid && !mem_req_ready) stall_seen <= stall_seen + 1;
         if (mem_req_valid && mem_req_ready) begin
            rd_log.push_back(mem_req_addr);
            if (mem_req_addr == delay_addr && delay_cycles > 0) begin
               pend   <= delay_cycles;
               pend_a <= mem_req_addr;
            end else begin
               mem_resp_valid <= 1'b1;
               mem_resp_data  <= rd(mem_req_addr);
               mem_resp_err   <= (mem_req_addr == err_addr);
            end
         end
      end
   end

   always @(posedge clk) begin
      if (fill_valid)  fill_cnt  <= fill_cnt + 1;
      if (fault_valid) fault_cnt <= fault_cnt + 1;
   end

   int          rd_base = 0;
   logic        c_fill, c_fault, c_glb;
   logic [35:0] c_vpn;
   logic [29:0] c_ppn;
   logic [5:0]  c_perm;
   logic [7:0]  c_asid;
   logic [2:0]  c_code;

   function automatic int reads();
      return rd_log.size() - rd_base;
   endfunction

   task automatic start_req(input logic [35:0] vpn, input logic [15:0] asid, input logic [29:0] root);
      int k;
      rd_base = rd_log.size();
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      req_vpn   = vpn;
      req_asid  = asid;
      root_ppn  = root;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic do_walk(input logic [35:0] vpn, input logic [15:0] asid, input logic [29:0] root,
                          output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      start_req(vpn, asid, root);
      for (int i = 1; i <= 60 && !seen; i++) begin
         @(negedge clk);
         if (fill_valid || fault_valid) begin
            seen = 1'b1;
            lat  = i;
            c_fill = fill_valid; c_fault = fault_valid; c_glb = fill_global;
            c_vpn  = fill_valid ? fill_vpn : fault_vpn;
            c_ppn  = fill_ppn; c_perm = fill_perm; c_asid = fill_asid; c_code = fault_code;
         end
      end
      if (!seen) chk("walk_timeout", 64'd0, 64'd1);
   endtask

   task automatic inv_pulse();
      @(negedge clk) inv = 1'b1;
      @(negedge clk) inv = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, f0, q0, k;
      bit seen;
      mem[48'h100000] = pte(30'h101, 6'h01);
      mem[48'h101000] = pte(30'h102, 6'h01);
      mem[48'h102000] = pte(30'h103, 6'h01);
      mem[48'h103008] = pte(30'h002, 6'h07);
      mem[48'h103010] = pte(30'h005, 6'h3B);

      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", {mem_req_valid, mem_req_addr}, 0);
      chk("rst_pulses", {fill_valid, fault_valid}, 0);
      rst = 1'b1;

      // basic four-level walk
      f0 = fill_cnt; q0 = fault_cnt;
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("basic_latency", lat, 9);
      chk("basic_kind", {c_fill, c_fault}, 2'b10);
      chk("basic_vpn", c_vpn, 36'h1);
      chk("basic_ppn", c_ppn, 30'h2);
      chk("basic_perm", c_perm, 6'b000011);
      chk("basic_global", c_glb, 0);
      chk("basic_asid", c_asid, 8'h01);
      chk("basic_reads", reads(), 4);
      chk("basic_addr0", rd_log[rd_base+0], 48'h100000);
      chk("basic_addr1", rd_log[rd_base+1], 48'h101000);
      chk("basic_addr2", rd_log[rd_base+2], 48'h102000);
      chk("basic_addr3", rd_log[rd_base+3], 48'h103008);
      @(negedge clk);
      chk("basic_pulse_once", {fill_valid, fill_cnt - f0, fault_cnt - q0}, {1'b0, 32'd1, 32'd0});
      chk("basic_ready_again", req_ready, 1);

      // same upper VPN bits: hit with the walk cache, full walk without it
      do_walk(36'h2, 16'hAB05, 30'h100, lat);
`ifdef PTW_CACHE_EN
      chk("vpn2_latency", lat, 3);
      chk("vpn2_reads", reads(), 1);
`else
      chk("vpn2_latency", lat, 9);
      chk("vpn2_reads", reads(), 4);
`endif
      chk("vpn2_last_addr", rd_log[rd_log.size()-1], 48'h103010);
      chk("vpn2_fill", {c_fill, c_ppn, c_perm, c_glb, c_asid},
          {1'b1, 30'h5, 6'b001101, 1'b1, 8'h05});
      inv_pulse();
      do_walk(36'h2, 16'hAB05, 30'h100, lat);
      chk("inv_reads", reads(), 4);
      chk("inv_latency", lat, 9);

      // level-1 PTE not present
      inv_pulse();
      mem[48'h102000] = pte(30'h103, 6'h00);
      f0 = fill_cnt;
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("np_kind", {c_fill, c_fault}, 2'b01);
      chk("np_code", c_code, 0);
      chk("np_vpn", c_vpn, 36'h1);
      chk("np_reads", reads(), 3);
      mem[48'h102000] = pte(30'h103, 6'h01);

      // leaf at level 2
      inv_pulse();
      mem[48'h101000] = pte(30'h102, 6'h03);
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("badleaf_code", {c_fault, c_code}, {1'b1, 3'd3});
      chk("badleaf_reads", reads(), 2);
      mem[48'h101000] = pte(30'h102, 6'h01);

      // bus error on the very first read
      inv_pulse();
      err_addr = 48'h100000;
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("buserr_code", {c_fault, c_code}, {1'b1, 3'd2});
      chk("buserr_reads", reads(), 1);
      @(negedge clk);
      chk("faults_no_fill", fill_cnt - f0, 0);
      err_addr = '1;

      // five stall cycles on the level-2 request
      inv_pulse();
      stall_addr = 48'h101000;
      stall_base = stall_seen;
      stall_req  = 5;
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("bp_latency", lat, 14);
      chk("bp_stall_cycles", stall_seen - stall_base, 5);
      chk("bp_reads", reads(), 4);
      chk("bp_addr1", rd_log[rd_base+1], 48'h101000);
      chk("bp_fill", {c_fill, c_ppn}, {1'b1, 30'h2});
      stall_req = 0;

      // abort while waiting on the level-1 read; response comes 3 cycles later
      inv_pulse();
      delay_addr = 48'h102000;
      delay_cycles = 3;
      f0 = fill_cnt; q0 = fault_cnt;
      start_req(36'h1, 16'h0001, 30'h100);
      k = 0;
      while (!(mem_req_valid && mem_req_ready && mem_req_addr == 48'h102000) && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reached_l1", k < 40, 1);
      @(posedge clk);
      @(negedge clk) abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_resp_valid) seen = 1'b1;
      end
      chk("abort_resp_seen", seen, 1);
      chk("abort_busy_during_resp", busy, 1);
      @(negedge clk);
      chk("abort_busy_after", {busy, req_ready}, 2'b01);
      chk("abort_no_pulse", {fill_cnt - f0, fault_cnt - q0}, 0);
      chk("abort_reads", reads(), 3);
      delay_addr = '1;
      delay_cycles = 0;
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("post_abort_walk", {c_fill, c_ppn, lat[7:0]}, {1'b1, 30'h2, 8'd9});

      // reset in the middle of a walk
      start_req(36'h1, 16'h0001, 30'h100);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_state", {busy, req_ready, mem_req_valid}, 3'b010);
      @(negedge clk) rst = 1'b1;
      do_walk(36'h1, 16'h0001, 30'h100, lat);
      chk("post_rst_walk", {c_fill, c_ppn, lat[7:0]}, {1'b1, 30'h2, 8'd9});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
